// File: rtl/store_narrow_if.sv
// rtl/store_narrow_if.sv - store request / memory write handshake bundle
//
// Purpose: groups the request side (datapath -> store_narrow) and the write
// side (store_narrow -> data memory) of the store-narrowing stage.
// Signals:
//   in_valid/in_ready, in_addr[ADDR_W], in_data[32], in_size[2]   request
//   out_valid/out_ready, out_addr[ADDR_W], out_wdata[32], out_be[4],
//   out_err, out_trunc                                             memory write
// Modports: master = requester/memory side, slave = store_narrow.
interface store_narrow_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_wdata;
  logic [3:0]        out_be;
  logic              out_err;
  logic              out_trunc;

  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_wdata, out_be, out_err, out_trunc
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_wdata, out_be, out_err, out_trunc
  );
endinterface

// File: rtl/store_narrow.sv
// rtl/store_narrow.sv - store-path narrowing, lane placement and output FIFO
//
// Purpose: narrows a 32-bit register value to byte/half/word, replicates it
// onto the little-endian byte lanes, generates byte enables, flags misaligned
// or illegal-size stores, and buffers results in a DEPTH-entry FIFO.
// Ports:
//   clk      clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   bus      store_narrow_if.slave (request in, memory write out)
//   err_cnt  count of errored entries popped, saturates at 255
// Parameters: ADDR_W byte-address width (>= 3), DEPTH FIFO entries (pow2, >= 2)
// Optional feature: define STORE_NARROW_TRUNC_CHECK_EN to compute out_trunc;
// otherwise out_trunc is tied to 0 and nothing is stored for it.
module store_narrow #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  store_narrow_if.slave  bus,
  output logic [7:0]     err_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_W - 2;

  // Only the word address is stored; the low two bits are always zero at the output.
  logic [WA_W-1:0]  mem_waddr [DEPTH];
  logic [31:0]      mem_wdata [DEPTH];
  logic [3:0]       mem_be    [DEPTH];
  logic             mem_err   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;

  logic [1:0]       lane;
  logic             enc_err;
  logic [3:0]       enc_be;
  logic [31:0]      enc_wdata;

  // Handshake flags depend on registered count only, so in_ready has no
  // combinational path from out_ready.
  assign bus.in_ready  = (count != CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Lane placement and alignment check on the incoming request.
  always_comb begin
    lane      = bus.in_addr[1:0];
    enc_err   = 1'b0;
    enc_be    = 4'b0000;
    enc_wdata = 32'h0;
    case (bus.in_size)
      2'b00: begin
        enc_be    = 4'b0001 << lane;
        enc_wdata = {4{bus.in_data[7:0]}};
      end
      2'b01: begin
        enc_err   = lane[0];
        enc_be    = lane[1] ? 4'b1100 : 4'b0011;
        enc_wdata = {2{bus.in_data[15:0]}};
      end
      2'b10: begin
        enc_err   = (lane != 2'b00);
        enc_be    = 4'b1111;
        enc_wdata = bus.in_data;
      end
      default: enc_err = 1'b1;
    endcase
    // Errored entries must not write anything to memory.
    if (enc_err) begin
      enc_be    = 4'b0000;
      enc_wdata = 32'h0;
    end
  end

`ifdef STORE_NARROW_TRUNC_CHECK_EN
  logic mem_trunc [DEPTH];
  logic enc_trunc;

  // Truncated when the upper bits are not a sign-extension of the stored width.
  always_comb begin
    enc_trunc = 1'b0;
    case (bus.in_size)
      2'b00:   enc_trunc = (bus.in_data[31:8]  != {24{bus.in_data[7]}});
      2'b01:   enc_trunc = (bus.in_data[31:16] != {16{bus.in_data[15]}});
      default: enc_trunc = 1'b0;
    endcase
    if (enc_err) enc_trunc = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_trunc[i] <= 1'b0;
    end else if (push) begin
      mem_trunc[wr_ptr] <= enc_trunc;
    end
  end

  assign bus.out_trunc = mem_trunc[rd_ptr];
`else
  assign bus.out_trunc = 1'b0;
`endif

  // FIFO storage; cleared on reset so the head reads as all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_waddr[i] <= '0;
        mem_wdata[i] <= 32'h0;
        mem_be[i]    <= 4'b0000;
        mem_err[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_waddr[wr_ptr] <= bus.in_addr[ADDR_W-1:2];
      mem_wdata[wr_ptr] <= enc_wdata;
      mem_be[wr_ptr]    <= enc_be;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (pop && mem_err[rd_ptr] && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.out_addr  = {mem_waddr[rd_ptr], 2'b00};
  assign bus.out_wdata = mem_wdata[rd_ptr];
  assign bus.out_be    = mem_be[rd_ptr];
  assign bus.out_err   = mem_err[rd_ptr];
endmodule

// File: tb/tb_store_narrow.sv
// tb/tb_store_narrow.sv - self-checking bench for store_narrow
module tb_store_narrow;
  localparam int DEPTH = 2;
`ifdef STORE_NARROW_TRUNC_CHECK_EN
  localparam bit TRUNC_ON = 1'b1;
`else
  localparam bit TRUNC_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic        trunc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;
  int         total = 0;
  int         bad = 0;

  ent_t       q[$];
  int         m_err = 0;

  store_narrow_if #(.ADDR_W(32)) ifc ();

  store_narrow #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (ifc),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Expected memory write derived from the store rules with plain arithmetic.
  function automatic ent_t exp_entry(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ent_t e;
    int   lane;
    lane    = int'(a % 4);
    e.addr  = a - 32'(lane);
    e.err   = 1'b0;
    e.trunc = 1'b0;
    e.be    = 4'h0;
    e.wdata = 32'h0;
    case (s)
      2'd0: begin
        e.be    = 4'(1 << lane);
        e.wdata = {24'h0, d[7:0]} * 32'h01010101;
        e.trunc = ($signed(d) < -128) || ($signed(d) > 127);
      end
      2'd1: begin
        e.err   = (lane % 2) != 0;
        e.be    = (lane >= 2) ? 4'hC : 4'h3;
        e.wdata = {16'h0, d[15:0]} * 32'h00010001;
        e.trunc = ($signed(d) < -32768) || ($signed(d) > 32767);
      end
      2'd2: begin
        e.err   = (lane != 0);
        e.be    = 4'hF;
        e.wdata = d;
      end
      default: e.err = 1'b1;
    endcase
    if (e.err || !TRUNC_ON) e.trunc = 1'b0;
    if (e.err) begin
      e.be    = 4'h0;
      e.wdata = 32'h0;
    end
    return e;
  endfunction

  // Reference FIFO: transactions happen whenever the handshake would complete.
  always @(posedge clk) begin
    if (rst_n) begin
      bit po;
      bit pu;
      po = ifc.out_ready && (q.size() > 0);
      pu = ifc.in_valid && (q.size() < DEPTH);
      if (po) begin
        if (q[0].err && m_err < 255) m_err++;
        void'(q.pop_front());
      end
      if (pu) q.push_back(exp_entry(ifc.in_addr, ifc.in_data, ifc.in_size));
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    m_err = 0;
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic r);
    ifc.in_valid  = v;
    ifc.in_addr   = a;
    ifc.in_data   = d;
    ifc.in_size   = s;
    ifc.out_ready = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
    total++; if ({ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err, ifc.out_trunc} !== 70'h0) begin
      bad++; $display("FAIL reset_head got=%h/%h/%h/%b/%b exp=0", ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err, ifc.out_trunc);
    end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte;
    @(negedge clk); drive(1, 32'h1003, 32'h000000A5, 2'd0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL byte_valid got=%b exp=1", ifc.out_valid); end
    total++; if (ifc.out_addr !== 32'h1000) begin bad++; $display("FAIL byte_addr got=%h exp=00001000", ifc.out_addr); end
    total++; if (ifc.out_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL byte_wdata got=%h exp=a5a5a5a5", ifc.out_wdata); end
    total++; if (ifc.out_be !== 4'b1000) begin bad++; $display("FAIL byte_be got=%b exp=1000", ifc.out_be); end
    total++; if (ifc.out_err !== 1'b0) begin bad++; $display("FAIL byte_err got=%b exp=0", ifc.out_err); end
    drive(0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL byte_drain got=%b exp=0", ifc.out_valid); end
  endtask

  task automatic test_half;
    @(negedge clk); drive(1, 32'h2002, 32'hFFFF8001, 2'd1, 0);
    @(negedge clk); drive(1, 32'h2002, 32'h00018001, 2'd1, 0);
    total++; if (ifc.out_wdata !== 32'h80018001) begin bad++; $display("FAIL half_wdata got=%h exp=80018001", ifc.out_wdata); end
    total++; if (ifc.out_be !== 4'b1100) begin bad++; $display("FAIL half_be got=%b exp=1100", ifc.out_be); end
    total++; if (ifc.out_trunc !== 1'b0) begin bad++; $display("FAIL half_trunc0 got=%b exp=0", ifc.out_trunc); end
    @(negedge clk); drive(0, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (ifc.out_wdata !== 32'h80018001) begin bad++; $display("FAIL half2_wdata got=%h exp=80018001", ifc.out_wdata); end
    total++; if (ifc.out_trunc !== TRUNC_ON) begin bad++; $display("FAIL half_trunc1 got=%b exp=%b", ifc.out_trunc, TRUNC_ON); end
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL half_drain got=%b exp=0", ifc.out_valid); end
  endtask

  task automatic test_word_err;
    @(negedge clk); drive(1, 32'h3001, 32'hDEADBEEF, 2'd2, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    total++; if ({ifc.out_err, ifc.out_be, ifc.out_wdata} !== {1'b1, 4'h0, 32'h0}) begin
      bad++; $display("FAIL word_err got=%b/%b/%h exp=1/0000/00000000", ifc.out_err, ifc.out_be, ifc.out_wdata);
    end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL word_cnt_pre got=%0d exp=0", err_cnt); end
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL word_cnt_post got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_back_to_back;
    ent_t ea, eb, ec;
    ea = exp_entry(32'h4000, 32'h11223344, 2'd2);
    eb = exp_entry(32'h4001, 32'h00000055, 2'd0);
    ec = exp_entry(32'h4006, 32'h00001234, 2'd1);
    @(negedge clk); drive(1, 32'h4000, 32'h11223344, 2'd2, 0);
    @(negedge clk); drive(1, 32'h4001, 32'h00000055, 2'd0, 0);
    @(negedge clk); drive(1, 32'h4006, 32'h00001234, 2'd1, 0);
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", ifc.in_ready); end
    @(negedge clk); drive(1, 32'h4006, 32'h00001234, 2'd1, 1);
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full2 got=%b exp=0", ifc.in_ready); end
    total++; if ({ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err} !== {ea.addr, ea.wdata, ea.be, ea.err}) begin
      bad++; $display("FAIL b2b_head_a got=%h/%h/%h exp=%h/%h/%h", ifc.out_addr, ifc.out_wdata, ifc.out_be, ea.addr, ea.wdata, ea.be);
    end
    @(negedge clk);
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", ifc.in_ready); end
    total++; if ({ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err} !== {eb.addr, eb.wdata, eb.be, eb.err}) begin
      bad++; $display("FAIL b2b_head_b got=%h/%h/%h exp=%h/%h/%h", ifc.out_addr, ifc.out_wdata, ifc.out_be, eb.addr, eb.wdata, eb.be);
    end
    @(negedge clk); drive(0, 0, 0, 0, 1);
    total++; if ({ifc.out_valid, ifc.out_addr, ifc.out_wdata, ifc.out_be} !== {1'b1, ec.addr, ec.wdata, ec.be}) begin
      bad++; $display("FAIL b2b_head_c got=%b/%h/%h/%h exp=1/%h/%h/%h", ifc.out_valid, ifc.out_addr, ifc.out_wdata, ifc.out_be, ec.addr, ec.wdata, ec.be);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", ifc.out_valid); end
  endtask

  task automatic test_stream;
    ent_t prev;
    logic [31:0] a, d;
    logic [1:0]  s;
    a = 32'h5000; d = 32'h0000007F; s = 2'd0;
    prev = exp_entry(a, d, s);
    @(negedge clk); drive(1, a, d, s, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if ({ifc.out_valid, ifc.in_ready} !== 2'b11) begin
        bad++; $display("FAIL stream_flags[%0d] got=%b%b exp=11", i, ifc.out_valid, ifc.in_ready);
      end
      total++; if ({ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err, ifc.out_trunc} !== {prev.addr, prev.wdata, prev.be, prev.err, prev.trunc}) begin
        bad++; $display("FAIL stream_head[%0d] got=%h/%h/%h exp=%h/%h/%h", i, ifc.out_addr, ifc.out_wdata, ifc.out_be, prev.addr, prev.wdata, prev.be);
      end
      a = $urandom; d = $urandom; s = 2'($urandom_range(0, 2));
      prev = exp_entry(a, d, s);
      drive(1, a, d, s, 1);
    end
    @(negedge clk); drive(0, 0, 0, 0, 1);
    total++; if (ifc.out_wdata !== prev.wdata) begin bad++; $display("FAIL stream_last got=%h exp=%h", ifc.out_wdata, prev.wdata); end
    @(negedge clk); drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      total++; if (ifc.in_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, ifc.in_ready, q.size() != DEPTH); end
      total++; if (ifc.out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, ifc.out_valid, q.size() != 0); end
      total++; if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rnd_err_cnt[%0d] got=%0d exp=%0d", i, err_cnt, m_err); end
      if (q.size() > 0) begin
        total++; if ({ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err, ifc.out_trunc} !== {q[0].addr, q[0].wdata, q[0].be, q[0].err, q[0].trunc}) begin
          bad++; $display("FAIL rnd_head[%0d] got=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/%b", i, ifc.out_addr, ifc.out_wdata, ifc.out_be, ifc.out_err, ifc.out_trunc,
                          q[0].addr, q[0].wdata, q[0].be, q[0].err, q[0].trunc);
        end
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = {{24{d[7]}}, d[7:0]};
      drive(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk); drive(0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); drive(1, 32'h6001, $urandom, 2'd2, 1);
    end
    @(negedge clk); drive(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); drive(1, 32'h7000, 32'h1, 2'd2, 0);
    @(negedge clk); drive(1, 32'h7004, 32'h2, 2'd2, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL arst_pre_full got=%b exp=0", ifc.in_ready); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", ifc.out_valid); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL arst_err_cnt got=%0d exp=0", err_cnt); end
    total++; if ({ifc.in_ready, ifc.out_addr, ifc.out_wdata, ifc.out_be} !== {1'b1, 68'h0}) begin
      bad++; $display("FAIL arst_state got=%b/%h/%h/%h exp=1/0/0/0", ifc.in_ready, ifc.out_addr, ifc.out_wdata, ifc.out_be);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got=%b exp=0", ifc.out_valid); end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_byte();
    test_half();
    test_word_err();
    test_back_to_back();
    test_stream();
    test_random();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
